// File: rtl/gpu_fb_pkg.sv
// Shared definitions for the framebuffer port arbiter.
// Widths, burst limit and the arbiter state/owner encodings.
package gpu_fb_pkg;

  localparam int FB_ADR_W     = 15;
  localparam int FB_DAT_W     = 32;
  localparam int FB_BURST_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } fb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } fb_owner_e;

  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    return (len > 6'(FB_BURST_MAX)) ? 6'(FB_BURST_MAX) : len;
  endfunction

endpackage

// File: rtl/gpu_fb_arbiter.sv
// Shares one framebuffer memory port between the video refill burst
// engine and the CPU slave, with bounded CPU wait inside a burst.
module gpu_fb_arbiter
  import gpu_fb_pkg::*;
#(
  parameter int CPU_EVERY = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                vid_req,
  input  logic [FB_ADR_W-1:0] vid_base,
  input  logic [5:0]          vid_len,
  output logic                vid_busy,
  output logic                vid_valid,
  output logic [FB_DAT_W-1:0] vid_dat,
  output logic [4:0]          vid_idx,
  output logic                vid_overrun,
  input  logic                cpu_stb,
  input  logic                cpu_we,
  input  logic [3:0]          cpu_sel,
  input  logic [FB_ADR_W-1:0] cpu_adr,
  input  logic [FB_DAT_W-1:0] cpu_dat_i,
  output logic                cpu_ack,
  output logic [FB_DAT_W-1:0] cpu_dat_o,
  output logic [FB_ADR_W-1:0] mem_adr_o,
  output logic [3:0]          mem_we_o,
  output logic [FB_DAT_W-1:0] mem_dat_o,
  input  logic [FB_DAT_W-1:0] mem_dat_i
);

  localparam logic [3:0] CPU_EV = 4'(CPU_EVERY);

  fb_state_e           state_q, state_d;
  fb_owner_e           own_q, own_d;
  logic [FB_ADR_W-1:0] base_q, base_d;
  logic [5:0]          rem_q, rem_d;
  logic [4:0]          idx_q, idx_d;
  logic [4:0]          ridx_q, ridx_d;
  logic [3:0]          vrun_q, vrun_d;
  logic                ovr_q, ovr_d;

  logic req_ok;
  logic cpu_elig;
  logic vid_slot;
  logic cpu_slot;

  // Slot choice; resetn gates the CPU so the port is quiet during reset
  always_comb begin
    req_ok   = vid_req & (vid_len != '0);
    cpu_elig = resetn & cpu_stb & (own_q != OWN_CPU);
    vid_slot = (state_q == BURST) &
               (~cpu_elig | (vrun_q < CPU_EV));
    cpu_slot = cpu_elig & ~vid_slot;
  end

  always_comb begin
    mem_adr_o = '0;
    mem_we_o  = '0;
    mem_dat_o = '0;
    unique case (1'b1)
      vid_slot: begin
        mem_adr_o = base_q + FB_ADR_W'(idx_q);
      end
      cpu_slot: begin
        mem_adr_o = cpu_adr;
        if (cpu_we) begin
          mem_we_o  = cpu_sel;
          mem_dat_o = cpu_dat_i;
        end
      end
      default: ;
    endcase
  end

  assign vid_busy    = (state_q != IDLE);
  assign vid_valid   = (own_q == OWN_VID);
  assign vid_idx     = ridx_q;
  assign vid_dat     = vid_valid ? mem_dat_i : '0;
  assign cpu_ack     = (own_q == OWN_CPU);
  assign cpu_dat_o   = cpu_ack ? mem_dat_i : '0;
  assign vid_overrun = ovr_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    ridx_d  = ridx_q;
    vrun_d  = vrun_q;
    own_d   = OWN_NONE;

    unique case (1'b1)
      vid_slot: begin
        own_d  = OWN_VID;
        ridx_d = idx_q;
      end
      cpu_slot: own_d = OWN_CPU;
      default:  ;
    endcase

    if (!cpu_elig || cpu_slot) begin
      vrun_d = '0;
    end else if (vid_slot) begin
      vrun_d = vrun_q + 4'd1;
    end

    if (vid_slot) begin
      idx_d = idx_q + 5'd1;
      rem_d = rem_q - 6'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d = BURST;
          base_d  = vid_base;
          rem_d   = clamp_len(vid_len);
          idx_d   = '0;
        end
      end
      BURST: begin
        if (req_ok) ovr_d = 1'b1;
        if (vid_slot && rem_q == 6'd1) state_d = DRAIN;
      end
      DRAIN: begin
        if (req_ok) begin
          state_d = BURST;
          base_d  = vid_base;
          rem_d   = clamp_len(vid_len);
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      own_q   <= OWN_NONE;
      base_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      ridx_q  <= '0;
      vrun_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      ridx_q  <= ridx_d;
      vrun_q  <= vrun_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_gpu_fb_arbiter.sv
// Directed scoreboard bench for gpu_fb_arbiter with a one-cycle
// read-latency framebuffer model behind the memory port.
module tb_gpu_fb_arbiter;

  logic        clk;
  logic        resetn;
  logic        vid_req;
  logic [14:0] vid_base;
  logic [5:0]  vid_len;
  logic        vid_busy;
  logic        vid_valid;
  logic [31:0] vid_dat;
  logic [4:0]  vid_idx;
  logic        vid_overrun;
  logic        cpu_stb;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [14:0] cpu_adr;
  logic [31:0] cpu_dat_i;
  logic        cpu_ack;
  logic [31:0] cpu_dat_o;
  logic [14:0] mem_adr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_dat_o;
  logic [31:0] mem_dat_i;

  gpu_fb_arbiter #(.CPU_EVERY(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .vid_req     (vid_req),
    .vid_base    (vid_base),
    .vid_len     (vid_len),
    .vid_busy    (vid_busy),
    .vid_valid   (vid_valid),
    .vid_dat     (vid_dat),
    .vid_idx     (vid_idx),
    .vid_overrun (vid_overrun),
    .cpu_stb     (cpu_stb),
    .cpu_we      (cpu_we),
    .cpu_sel     (cpu_sel),
    .cpu_adr     (cpu_adr),
    .cpu_dat_i   (cpu_dat_i),
    .cpu_ack     (cpu_ack),
    .cpu_dat_o   (cpu_dat_o),
    .mem_adr_o   (mem_adr_o),
    .mem_we_o    (mem_we_o),
    .mem_dat_o   (mem_dat_o),
    .mem_dat_i   (mem_dat_i)
  );

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] dat;
  } vexp_t;

  typedef struct packed {
    logic        rd;
    logic [31:0] dat;
  } cexp_t;

  vexp_t vq[$];
  cexp_t cq[$];
  vexp_t mve;
  cexp_t mce;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;

  logic [31:0] mem [0:32767];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [14:0] a);
    return {a ^ 15'h2A5C, 2'b11, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Read-first single-port memory, one cycle read latency
  always @(posedge clk) begin
    if (|mem_we_o)
      mem[mem_adr_o] <= merge(mem[mem_adr_o], mem_dat_o, mem_we_o);
    mem_dat_i <= mem[mem_adr_o];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vid_valid) begin
      vcnt++;
      chk("vid_q_nonempty", 64'(vq.size() != 0), 64'(1));
      if (vq.size() != 0) begin
        mve = vq.pop_front();
        chk("vid_idx", 64'(vid_idx), 64'(mve.idx));
        chk("vid_dat", 64'(vid_dat), 64'(mve.dat));
      end
    end
    if (cpu_ack) begin
      chk("cpu_q_nonempty", 64'(cq.size() != 0), 64'(1));
      if (cq.size() != 0) begin
        mce = cq.pop_front();
        if (mce.rd) chk("cpu_dat", 64'(cpu_dat_o), 64'(mce.dat));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vid_start(input logic [14:0] b, input logic [5:0] l,
                           input int np);
    vexp_t t;
    for (int i = 0; i < np; i++) begin
      t.idx = 5'(i);
      t.dat = pat(b + 15'(i));
      vq.push_back(t);
    end
    vid_base = b;
    vid_len  = l;
    vid_req  = 1'b1;
    tick();
    vid_req  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (vid_busy && k < 300) begin
      tick();
      k++;
    end
    chk(tag, 64'(vid_busy), 64'(0));
  endtask

  task automatic cpu_wait(input string tag, output int lat);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!cpu_ack && k < 50);
    chk(tag, 64'(cpu_ack), 64'(1));
    cpu_stb = 1'b0;
    lat = k;
    tick();
  endtask

  initial begin
    int nb, k, lat, vc0;
    logic [31:0] e;
    logic [14:0] ea;
    cexp_t ct;

    for (int i = 0; i < 32768; i++) mem[i] = pat(15'(i));
    resetn    = 1'b0;
    vid_req   = 1'b0;
    vid_base  = '0;
    vid_len   = '0;
    cpu_stb   = 1'b0;
    cpu_we    = 1'b0;
    cpu_sel   = '0;
    cpu_adr   = '0;
    cpu_dat_i = '0;
    repeat (3) tick();

    chk("rst_busy",  64'(vid_busy),    64'(0));
    chk("rst_valid", 64'(vid_valid),   64'(0));
    chk("rst_ovr",   64'(vid_overrun), 64'(0));
    chk("rst_ack",   64'(cpu_ack),     64'(0));
    chk("rst_adr",   64'(mem_adr_o),   64'(0));
    chk("rst_we",    64'(mem_we_o),    64'(0));
    resetn = 1'b1;
    tick();

    // full-length uncontended burst
    vc0 = vcnt;
    vid_start(15'h0100, 6'd32, 32);
    chk("t1_busy",  64'(vid_busy),  64'(1));
    chk("t1_adr0",  64'(mem_adr_o), 64'(15'h0100));
    chk("t1_valid", 64'(vid_valid), 64'(0));
    nb = 0;
    k  = 0;
    while (vid_busy && k < 100) begin
      nb++;
      tick();
      k++;
    end
    chk("t1_busy_cycles", 64'(nb), 64'(33));
    tick();
    chk("t1_words", 64'(vcnt - vc0), 64'(32));

    // byte-lane write then read back
    cpu_we    = 1'b1;
    cpu_sel   = 4'b0010;
    cpu_adr   = 15'h0005;
    cpu_dat_i = 32'hAABBCCDD;
    ct.rd = 1'b0;
    ct.dat = '0;
    cq.push_back(ct);
    cpu_stb = 1'b1;
    #1;
    chk("wr_we",  64'(mem_we_o),  64'(4'b0010));
    chk("wr_adr", 64'(mem_adr_o), 64'(15'h0005));
    chk("wr_dat", 64'(mem_dat_o), 64'(32'hAABBCCDD));
    cpu_wait("wr_ack", lat);
    chk("wr_lat", 64'(lat), 64'(1));
    e = pat(15'h0005);
    e[15:8] = 8'hCC;
    cpu_we = 1'b0;
    ct.rd = 1'b1;
    ct.dat = e;
    cq.push_back(ct);
    cpu_stb = 1'b1;
    #1;
    chk("rd_we0", 64'(mem_we_o), 64'(0));
    cpu_wait("rd_ack", lat);

    // CPU read waiting inside a 16-word burst
    vc0 = vcnt;
    vid_start(15'h0200, 6'd16, 16);
    cpu_we  = 1'b0;
    cpu_adr = 15'h0300;
    ct.rd = 1'b1;
    ct.dat = pat(15'h0300);
    cq.push_back(ct);
    cpu_stb = 1'b1;
    nb  = 0;
    lat = -1;
    k   = 0;
    while ((vid_busy || lat < 0) && k < 100) begin
      if (vid_busy) nb++;
      if (k == 4) chk("t2_cpu_slot", 64'(mem_adr_o), 64'(15'h0300));
      if (cpu_ack && lat < 0) begin
        lat = k;
        cpu_stb = 1'b0;
      end
      tick();
      k++;
    end
    chk("t2_cpu_lat", 64'(lat), 64'(5));
    chk("t2_burst_le21", 64'(nb <= 21), 64'(1));
    tick();
    chk("t2_words", 64'(vcnt - vc0), 64'(16));

    // new request in the DRAIN cycle chains a second burst
    vid_start(15'h0600, 6'd4, 4);
    repeat (4) tick();
    chk("dr_valid", 64'(vid_valid), 64'(1));
    chk("dr_idx",   64'(vid_idx),   64'(3));
    vid_start(15'h0700, 6'd3, 3);
    chk("dr_busy", 64'(vid_busy),  64'(1));
    chk("dr_adr0", 64'(mem_adr_o), 64'(15'h0700));
    wait_idle("dr_idle");
    chk("dr_no_ovr", 64'(vid_overrun), 64'(0));

    // address wrap, with a zero-length request mid-burst
    vid_start(15'h7FFE, 6'd4, 4);
    for (int i = 0; i < 4; i++) begin
      ea = 15'h7FFE + 15'(i);
      chk("wrap_adr", 64'(mem_adr_o), 64'(ea));
      if (i == 1) begin
        vid_len = 6'd0;
        vid_req = 1'b1;
      end else begin
        vid_req = 1'b0;
      end
      tick();
    end
    vid_req = 1'b0;
    wait_idle("wrap_idle");
    chk("len0_no_ovr", 64'(vid_overrun), 64'(0));

    vc0 = vcnt;
    vid_start(15'h0900, 6'd0, 0);
    chk("len0_busy", 64'(vid_busy), 64'(0));
    repeat (4) tick();
    chk("len0_words", 64'(vcnt - vc0), 64'(0));

    vc0 = vcnt;
    vid_start(15'h0A00, 6'd40, 32);
    wait_idle("len40_idle");
    tick();
    chk("len40_words", 64'(vcnt - vc0), 64'(32));

    // request while busy is dropped and flagged
    vc0 = vcnt;
    vid_start(15'h0400, 6'd8, 8);
    repeat (2) tick();
    vid_start(15'h0500, 6'd4, 0);
    chk("ovr_set", 64'(vid_overrun), 64'(1));
    wait_idle("ovr_idle");
    tick();
    chk("ovr_sticky", 64'(vid_overrun), 64'(1));
    chk("ovr_words", 64'(vcnt - vc0), 64'(8));

    // reset with a burst and a CPU read in flight
    vid_start(15'h0800, 6'd16, 3);
    cpu_we  = 1'b0;
    cpu_adr = 15'h0010;
    cpu_stb = 1'b1;
    repeat (4) tick();
    resetn = 1'b0;
    #1;
    chk("ar_busy",  64'(vid_busy),    64'(0));
    chk("ar_valid", 64'(vid_valid),   64'(0));
    chk("ar_ovr",   64'(vid_overrun), 64'(0));
    chk("ar_ack",   64'(cpu_ack),     64'(0));
    chk("ar_adr",   64'(mem_adr_o),   64'(0));
    chk("ar_we",    64'(mem_we_o),    64'(0));
    chk("ar_mdat",  64'(mem_dat_o),   64'(0));
    chk("ar_vdat",  64'(vid_dat),     64'(0));
    chk("ar_vidx",  64'(vid_idx),     64'(0));
    chk("ar_cdat",  64'(cpu_dat_o),   64'(0));
    repeat (2) tick();
    cpu_stb = 1'b0;
    resetn  = 1'b1;
    repeat (3) tick();
    chk("pr_busy",  64'(vid_busy),  64'(0));
    chk("pr_valid", 64'(vid_valid), 64'(0));
    chk("pr_ack",   64'(cpu_ack),   64'(0));

    chk("vq_empty", 64'(vq.size()), 64'(0));
    chk("cq_empty", 64'(cq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
